// File: rtl/mips_pkg.sv
// Shared register-file types and widths for the writeback path.
// Provides register/data widths, the zero-register index and the
// writeback entry payload {live, dst, data}.
package mips_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 32;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // One buffered long-latency result; live=0 means it was overwritten (WAW)
   typedef struct packed {
      logic              live;
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Bus bundle for reg_writeback.
// Groups ALU result inputs, the long-result valid/ready handshake,
// the register-file write port, the pending mask and the ALU stall.
// master: upstream pipeline / register file side; slave: reg_writeback.
interface reg_writeback_if import mips_pkg::*; ();

   logic              alu_valid;
   logic [REG_W-1:0]  alu_reg;
   logic [DATA_W-1:0] alu_data;

   logic              lng_valid;
   logic              lng_ready;
   logic [REG_W-1:0]  lng_reg;
   logic [DATA_W-1:0] lng_data;

   logic [REG_W-1:0]  write_reg;
   logic [DATA_W-1:0] write_data;
   logic              RegWrite;

   logic [NUM_REGS-1:0] pend;
   logic                alu_stall;

   modport master (
      output alu_valid, alu_reg, alu_data,
      output lng_valid, lng_reg, lng_data,
      input  lng_ready,
      input  write_reg, write_data, RegWrite,
      input  pend, alu_stall
   );

   modport slave (
      input  alu_valid, alu_reg, alu_data,
      input  lng_valid, lng_reg, lng_data,
      output lng_ready,
      output write_reg, write_data, RegWrite,
      output pend, alu_stall
   );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending long-latency writeback entries.
// Ports: clk, rst (sync, active-low); push/push_entry enqueue at the tail;
// pop dequeues the head; kill/kill_reg clear the live bit of every entry
// (including the one being pushed) targeting kill_reg; head is the current
// head entry; count is the registered occupancy; pend is the mask of
// destinations of live entries (bit 0 forced low).
module wb_fifo import mips_pkg::*; #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  wb_entry_t                 push_entry,
   input  logic                      pop,
   input  logic                      kill,
   input  logic [REG_W-1:0]          kill_reg,
   output wb_entry_t                 head,
   output logic [$clog2(DEPTH):0]    count,
   output logic [NUM_REGS-1:0]       pend
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   wb_entry_t        push_kept;

   // An entry pushed alongside a same-register ALU write is older, so it dies
   always_comb begin
      push_kept      = push_entry;
      push_kept.live = push_entry.live && !(kill && (push_entry.dst == kill_reg));
   end

   // Storage, pointers and occupancy; popped slots drop their live bit so
   // pend only needs to scan live flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (kill && (mem[i].dst == kill_reg)) begin
               mem[i].live <= 1'b0;
            end
         end
         if (pop) begin
            mem[rd_ptr].live <= 1'b0;
            rd_ptr           <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            mem[wr_ptr] <= push_kept;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head = mem[rd_ptr];

   // Pending-destination mask from live entries
   always_comb begin
      pend = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (mem[i].live) begin
            pend[mem[i].dst] = 1'b1;
         end
      end
      pend[0] = 1'b0;
   end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port driver.
// Merges single-cycle ALU results (priority) with buffered long-latency
// results into one registered write per cycle.
// Ports: clk; rst (sync, active-low); bus (reg_writeback_if.slave) carrying
// alu_valid/alu_reg/alu_data, lng_valid/lng_ready/lng_reg/lng_data,
// write_reg/write_data/RegWrite, pend and alu_stall.
module reg_writeback import mips_pkg::*; #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic           clk,
   input  logic           rst,
   reg_writeback_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned AGE_W = 4;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

   wb_entry_t           head;
   wb_entry_t           push_entry;
   logic [CNT_W-1:0]    count;
   logic [AGE_W-1:0]    age;
   logic [NUM_REGS-1:0] pend_mask;
   logic                fifo_empty_c;
   logic                alu_write_c;
   logic                pop_c;
   logic                push_c;

   assign fifo_empty_c = (count == '0);
   assign alu_write_c  = bus.alu_valid && (bus.alu_reg != REG_ZERO);
   // The FIFO only gets the port when the ALU is idle; no same-cycle bypass
   assign pop_c        = !bus.alu_valid && !fifo_empty_c;
   // r0 results complete the handshake but are dropped
   assign push_c       = bus.lng_valid && bus.lng_ready && (bus.lng_reg != REG_ZERO);
   assign push_entry   = {1'b1, bus.lng_reg, bus.lng_data};

   // Ready from registered occupancy only; a same-cycle pop does not free a slot
   assign bus.lng_ready = rst && (count < FULL_CNT);
   assign bus.alu_stall = (age == AGE_MAX) || (count == FULL_CNT);
   assign bus.pend      = pend_mask;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_c),
      .push_entry (push_entry),
      .pop        (pop_c),
      .kill       (alu_write_c),
      .kill_reg   (bus.alu_reg),
      .head       (head),
      .count      (count),
      .pend       (pend_mask)
   );

   // Head-of-FIFO wait counter, saturating at the starvation limit
   always_ff @(posedge clk) begin
      if (!rst) begin
         age <= '0;
      end else if (fifo_empty_c || pop_c) begin
         age <= '0;
      end else if (age != AGE_MAX) begin
         age <= age + AGE_W'(1);
      end
   end

   // Write-port registers; index/data hold when nothing is selected
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.write_reg  <= '0;
         bus.write_data <= '0;
         bus.RegWrite   <= 1'b0;
      end else if (bus.alu_valid) begin
         bus.write_reg  <= bus.alu_reg;
         bus.write_data <= bus.alu_data;
         bus.RegWrite   <= (bus.alu_reg != REG_ZERO);
      end else if (pop_c) begin
         bus.write_reg  <= head.dst;
         bus.write_data <= head.data;
         bus.RegWrite   <= head.live && (head.dst != REG_ZERO);
      end else begin
         bus.RegWrite   <= 1'b0;
      end
   end

endmodule
